dac_batch_fifo: RTL and testbench
=================================

# dac_batch_fifo

Elastic buffer between the system's DAC batch output and the DAC's AXI-stream input. `sys` produces one `BATCH_WIDTH` batch per `valid_dac_batch` pulse with no backpressure. The DAC accepts data only when ready. This block absorbs the mismatch with a prefill-gated FIFO and reports overflow and underrun conditions for the PS status registers.

## Interface
Parameters:
- `BATCH_WIDTH`, default `` `BATCH_WIDTH ``: width of one DAC batch.
- `DEPTH`, default 16: FIFO entries. Must be a power of 2, ≥ 4.
- `PREFILL`, default 8: entries required before streaming starts or restarts. Range 1..DEPTH.

Ports:
- `clk`  in  1: system clock.
- `pl_rstn`  in  1: asynchronous, active-low reset.
- `in_batch`  in  BATCH_WIDTH: batch from `sys`.
- `in_valid`  in  1: `in_batch` is valid this cycle. No ready is returned upstream.
- `flush`  in  1: synchronous clear of FIFO contents and the overflow flag.
- `dac_tdata`  out  BATCH_WIDTH: batch to the DAC.
- `dac_tvalid`  out  1: AXI-stream valid.
- `dac_tready`  in  1: AXI-stream ready; wired to `dac0_rdy`.
- `fill_level`  out  $clog2(DEPTH)+1: current entry count.
- `overflow`  out  1: sticky; set when a batch was dropped.
- `underrun_cnt`  out  16: saturating count of stream starvations.

## Operation
- Storage: DEPTH×BATCH_WIDTH RAM with synchronous write and asynchronous read. Write and read pointers are $clog2(DEPTH) bits and wrap naturally. `count` is a separate register.
- `push = in_valid & (count<DEPTH | pop)`.
- `pop = dac_tvalid & dac_tready`.
- Push and pop in the same cycle leave `count` unchanged. This holds when full, so a full FIFO that is popping still accepts the write.
- `in_valid` with the FIFO full and no pop: the batch is dropped and `overflow` sets to 1.
- States:
  - FILL: `dac_tvalid`=0. Go to STREAM at the edge where the next count ≥ PREFILL.
  - STREAM: `dac_tvalid`=(`count`≠0). Go to FILL at the edge where the next count = 0; on that edge, `underrun_cnt` increments, saturating at 0xFFFF.
- AXI-stream rule:
  - Once `dac_tvalid` is high, it and `dac_tdata` hold until `pop`. This is guaranteed because `count` can reach 0 only through a pop.
  - The only exception is `flush` or reset.
- `flush` has priority over everything:
  - next cycle: pointers=0, `count`=0, state=FILL, `overflow`=0;
  - `in_valid` in the same cycle is discarded and not flagged as overflow;
  - `underrun_cnt` is preserved.
- `dac_tdata` = `mem[rptr]` at all times. It is meaningful only while `dac_tvalid`=1.

## Timing
- Reset (async assert, sync release):
  - `dac_tvalid`=0, `fill_level`=0, `overflow`=0, `underrun_cnt`=0, state=FILL, pointers=0;
  - RAM and `dac_tdata` are not reset; their value is don't-care.
- `fill_level` is registered and reflects pushes and pops from the previous edge.
- Latency: a batch written at edge k that brings `count` to PREFILL produces `dac_tvalid`=1 during cycle k+1, with `dac_tdata` = the oldest entry.
- `overflow` is visible the cycle after the drop. `underrun_cnt` is visible the cycle after the STREAM→FILL edge.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Add `` `DAC_FIFO_DEPTH `` and `` `DAC_FIFO_PREFILL `` to the shared defines next to `` `BATCH_WIDTH ``.
- Add the state enum `dac_fifo_state_t {FILL, STREAM}` to `mem_layout_pkg`.
- One sub-module: `dac_fifo_mem`, a simple dual-port RAM with synchronous write and asynchronous read, mapped to distributed RAM. Pointers, count, FSM and status logic stay in `dac_batch_fifo`.

## Test plan
DEPTH=16, PREFILL=8; batch n carries value n.
1. Prefill gate: reset, `dac_tready`=1, push batches 1..7 → `dac_tvalid`=0, `fill_level`=7. Push batch 8 → next cycle `dac_tvalid`=1, `dac_tdata`=1.
2. Steady state: after prefill, push every cycle with `dac_tready`=1 for 100 cycles → `fill_level` constant at 8, output order 1,2,3…, `underrun_cnt`=0.
3. Overflow: `dac_tready`=0, push 1..17 → `fill_level`=16, `overflow`=1 the cycle after push 17. Then `dac_tready`=1 drains exactly 1..16.
4. Underrun: stream at fill 8, stop pushing → 8 pops, then `dac_tvalid`=0 and `underrun_cnt`=1. Seven pushes keep `dac_tvalid`=0; the 8th restarts it.
5. Backpressure stability: toggle `dac_tready` randomly while streaming → `dac_tdata` never changes while `dac_tvalid`=1 and `dac_tready`=0.
6. Flush and reset:
   - `flush`+`in_valid` mid-stream with `overflow`=1 → next cycle `fill_level`=0, `dac_tvalid`=0, `overflow`=0, `underrun_cnt` unchanged.
   - Drop `pl_rstn` between edges → all outputs take reset values immediately.

Source files
------------

// File: rtl/dac_batch_fifo_pkg.sv
// Shared defines and types for the DAC batch FIFO.
//
// Defines (overridable on the command line):
//   BATCH_WIDTH       width of one DAC batch
//   DAC_FIFO_DEPTH    FIFO entries (power of 2, >= 4)
//   DAC_FIFO_PREFILL  entries required before streaming starts or restarts
//
// Package contents:
//   DAC_BATCH_WIDTH, DAC_FIFO_DEPTH_P, DAC_FIFO_PREFILL_P  defaults taken from the defines
//   dac_fifo_state_t                                       FILL / STREAM state enum
//   sat_inc16                                              saturating 16-bit increment

`ifndef BATCH_WIDTH
`define BATCH_WIDTH 32
`endif
`ifndef DAC_FIFO_DEPTH
`define DAC_FIFO_DEPTH 16
`endif
`ifndef DAC_FIFO_PREFILL
`define DAC_FIFO_PREFILL 8
`endif

package dac_batch_fifo_pkg;

    localparam int unsigned DAC_BATCH_WIDTH    = `BATCH_WIDTH;
    localparam int unsigned DAC_FIFO_DEPTH_P   = `DAC_FIFO_DEPTH;
    localparam int unsigned DAC_FIFO_PREFILL_P = `DAC_FIFO_PREFILL;

    typedef enum logic [0:0] {
        FILL,
        STREAM
    } dac_fifo_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dac_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read (distributed RAM).
// Contents are not reset.
//
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational from raddr_i)

module dac_fifo_mem #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dac_batch_fifo.sv
// Prefill-gated elastic buffer between the system's DAC batch output (no
// backpressure) and the DAC's AXI-stream input. Reports dropped batches and
// stream starvations.
//
// Ports:
//   clk           system clock
//   pl_rstn       asynchronous active-low reset
//   in_batch      batch from the producer
//   in_valid      in_batch valid this cycle (no ready returned)
//   flush         synchronous clear of contents and overflow flag
//   dac_tdata     batch to the DAC (meaningful while dac_tvalid)
//   dac_tvalid    AXI-stream valid
//   dac_tready    AXI-stream ready
//   fill_level    current entry count (registered)
//   overflow      sticky, set when a batch was dropped
//   underrun_cnt  saturating count of STREAM->FILL transitions

module dac_batch_fifo
    import dac_batch_fifo_pkg::*;
#(
    parameter int unsigned BATCH_WIDTH = DAC_BATCH_WIDTH,
    parameter int unsigned DEPTH       = DAC_FIFO_DEPTH_P,
    parameter int unsigned PREFILL     = DAC_FIFO_PREFILL_P
) (
    input  logic                     clk,
    input  logic                     pl_rstn,
    input  logic [BATCH_WIDTH-1:0]   in_batch,
    input  logic                     in_valid,
    input  logic                     flush,
    output logic [BATCH_WIDTH-1:0]   dac_tdata,
    output logic                     dac_tvalid,
    input  logic                     dac_tready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [15:0]              underrun_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    dac_fifo_state_t state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     underrun_q, underrun_d;

    logic push;
    logic pop;

    // count is never 0 in STREAM (entered at >= PREFILL, left when it hits 0),
    // so valid can only drop after a pop; the explicit term keeps that obvious.
    assign dac_tvalid = (state_q == STREAM) && (count_q != '0);
    assign pop        = dac_tvalid & dac_tready;
    // A full FIFO that is popping frees a slot on the same edge.
    assign push       = in_valid & ((count_q < CW'(DEPTH)) | pop);

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        underrun_d = underrun_q;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        if (in_valid && !push) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            FILL: begin
                if (count_d >= CW'(PREFILL)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (count_d == '0) begin
                    state_d    = FILL;
                    underrun_d = sat_inc16(underrun_q);
                end
            end
            default: state_d = FILL;
        endcase

        // Flush overrides everything except the underrun counter.
        if (flush) begin
            state_d    = FILL;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk or negedge pl_rstn) begin
        if (!pl_rstn) begin
            state_q    <= FILL;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    dac_fifo_mem #(
        .WIDTH  (BATCH_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push & ~flush),
        .waddr_i (wptr_q),
        .wdata_i (in_batch),
        .raddr_i (rptr_q),
        .rdata_o (dac_tdata)
    );

    assign fill_level   = count_q;
    assign overflow     = overflow_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_dac_batch_fifo.sv
// Directed bench for dac_batch_fifo with DEPTH=16, PREFILL=8; batch n carries value n.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.

module tb_dac_batch_fifo;

    localparam int unsigned BW = 32;

    logic          clk;
    logic          pl_rstn;
    logic [BW-1:0] in_batch;
    logic          in_valid;
    logic          flush;
    logic [BW-1:0] dac_tdata;
    logic          dac_tvalid;
    logic          dac_tready;
    logic [4:0]    fill_level;
    logic          overflow;
    logic [15:0]   underrun_cnt;

    int unsigned errors;
    int unsigned checks;

    // Random-phase model
    int unsigned q[$];
    bit          m_stream;
    int unsigned m_under;
    bit          m_push;
    bit          m_pop;
    bit          exp_tv;
    bit          prev_stall;
    logic [BW-1:0] prev_data;

    dac_batch_fifo #(
        .BATCH_WIDTH (BW),
        .DEPTH       (16),
        .PREFILL     (8)
    ) dut (
        .clk          (clk),
        .pl_rstn      (pl_rstn),
        .in_batch     (in_batch),
        .in_valid     (in_valid),
        .flush        (flush),
        .dac_tdata    (dac_tdata),
        .dac_tvalid   (dac_tvalid),
        .dac_tready   (dac_tready),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int unsigned v);
        in_batch = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        pl_rstn    = 1'b0;
        in_batch   = '0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        dac_tready = 1'b0;

        #12;
        check("rst_tvalid", 32'(dac_tvalid), 0);
        check("rst_fill", 32'(fill_level), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_under", 32'(underrun_cnt), 0);
        pl_rstn = 1'b1;
        step();

        // 1. Prefill gate
        dac_tready = 1'b1;
        for (int n = 1; n <= 7; n++) push_one(n);
        check("pf_tvalid7", 32'(dac_tvalid), 0);
        check("pf_fill7", 32'(fill_level), 7);
        push_one(8);
        check("pf_tvalid8", 32'(dac_tvalid), 1);
        check("pf_tdata8", dac_tdata, 1);
        check("pf_fill8", 32'(fill_level), 8);

        // 2. Steady state: push and pop every cycle
        for (int i = 0; i < 100; i++) begin
            check("ss_tvalid", 32'(dac_tvalid), 1);
            check("ss_tdata", dac_tdata, 32'(i + 1));
            push_one(i + 9);
            check("ss_fill", 32'(fill_level), 8);
        end
        check("ss_under", 32'(underrun_cnt), 0);

        // 4. Underrun: stop pushing, drain 101..108
        for (int i = 0; i < 8; i++) begin
            check("ur_tvalid", 32'(dac_tvalid), 1);
            check("ur_tdata", dac_tdata, 32'(101 + i));
            step();
        end
        check("ur_tvalid0", 32'(dac_tvalid), 0);
        check("ur_fill0", 32'(fill_level), 0);
        check("ur_cnt1", 32'(underrun_cnt), 1);
        for (int n = 1; n <= 7; n++) begin
            push_one(n);
            check("ur_refill_tv", 32'(dac_tvalid), 0);
        end
        push_one(8);
        check("ur_restart_tv", 32'(dac_tvalid), 1);
        check("ur_restart_td", dac_tdata, 1);

        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl1_fill", 32'(fill_level), 0);
        check("fl1_under", 32'(underrun_cnt), 1);

        // 3. Overflow with no pops
        dac_tready = 1'b0;
        for (int n = 1; n <= 16; n++) push_one(n);
        check("of_fill16", 32'(fill_level), 16);
        check("of_ovf_pre", 32'(overflow), 0);
        push_one(17);
        check("of_fill_after", 32'(fill_level), 16);
        check("of_ovf", 32'(overflow), 1);
        dac_tready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("of_drain_tv", 32'(dac_tvalid), 1);
            check("of_drain_td", dac_tdata, 32'(i));
            step();
        end
        check("of_empty_tv", 32'(dac_tvalid), 0);
        check("of_under2", 32'(underrun_cnt), 2);
        check("of_ovf_sticky", 32'(overflow), 1);

        // 5. Random backpressure against a queue model
        m_stream   = 1'b0;
        m_under    = 2;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 200; i++) begin
            exp_tv = m_stream && (q.size() != 0);
            check("bp_tvalid", 32'(dac_tvalid), 32'(exp_tv));
            check("bp_fill", 32'(fill_level), q.size());
            if (exp_tv) check("bp_tdata", dac_tdata, q[0]);
            if (prev_stall) begin
                check("bp_hold_tv", 32'(dac_tvalid), 1);
                check("bp_hold_td", dac_tdata, prev_data);
            end
            dac_tready = 1'($urandom_range(0, 1));
            in_valid   = ($urandom_range(0, 9) < 6);
            in_batch   = 1000 + i;
            m_pop      = exp_tv && dac_tready;
            m_push     = in_valid && ((q.size() < 16) || m_pop);
            prev_stall = exp_tv && !dac_tready;
            prev_data  = dac_tdata;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(1000 + i);
            if (!m_stream && q.size() >= 8) begin
                m_stream = 1'b1;
            end else if (m_stream && q.size() == 0) begin
                m_stream = 1'b0;
                m_under++;
            end
            step();
        end
        in_valid = 1'b0;
        check("bp_under", 32'(underrun_cnt), m_under);

        // 6. Flush mid-stream with overflow set
        flush = 1'b1;
        step();
        flush = 1'b0;
        dac_tready = 1'b0;
        for (int n = 1; n <= 17; n++) push_one(n);
        check("fl_pre_ovf", 32'(overflow), 1);
        check("fl_pre_tv", 32'(dac_tvalid), 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_batch = 99;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_fill", 32'(fill_level), 0);
        check("fl_tv", 32'(dac_tvalid), 0);
        check("fl_ovf", 32'(overflow), 0);
        check("fl_under", 32'(underrun_cnt), m_under);
        step();
        check("fl_fill_after", 32'(fill_level), 0);

        // Async reset between edges
        for (int n = 1; n <= 17; n++) push_one(n);
        check("ar_pre_tv", 32'(dac_tvalid), 1);
        check("ar_pre_ovf", 32'(overflow), 1);
        #2;
        pl_rstn = 1'b0;
        #1;
        check("ar_tv", 32'(dac_tvalid), 0);
        check("ar_fill", 32'(fill_level), 0);
        check("ar_ovf", 32'(overflow), 0);
        check("ar_under", 32'(underrun_cnt), 0);
        step();
        pl_rstn = 1'b1;
        step();
        check("ar_post_fill", 32'(fill_level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
